// File: rtl/sopc_nios2_0_oci_pkg.sv
// sopc_nios2_0_oci_pkg: shared states, DCT codes and frame layout for the OCI DCT packer
package sopc_nios2_0_oci_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, FULL_WAIT, FLUSH_WAIT} dct_state_e;
    localparam logic [1:0] DCT_NONE      = 2'b00;
    localparam logic [1:0] DCT_NOT_TAKEN = 2'b10;
    localparam logic [1:0] DCT_TAKEN     = 2'b11;
    localparam int FRAME_BUF_LSB = 0;
    localparam int FRAME_CNT_LSB = 30;
    localparam int FRAME_W       = 34;
endpackage

// File: rtl/sopc_nios2_0_oci_frame_slot.sv
// sopc_nios2_0_oci_frame_slot: single-entry valid/ready output register (load, retire, slot_free)
module sopc_nios2_0_oci_frame_slot #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         slot_free
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    always_comb begin
        valid_d = load || (valid_q && !ready);
        data_d  = load ? load_data : data_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign valid     = valid_q;
    assign data      = data_q;
    assign slot_free = !valid_q || ready;
endmodule

// File: rtl/sopc_nios2_0_oci_dct_packer.sv
// sopc_nios2_0_oci_dct_packer: packs 2-bit DCT codes into frames emitted on fill or flush
module sopc_nios2_0_oci_dct_packer
    import sopc_nios2_0_oci_pkg::*;
#(
    parameter int DCT_MAX = 15,
    parameter int DROP_W  = 8,
    localparam int BUF_W  = 2 * DCT_MAX,
    localparam int CNT_W  = $clog2(DCT_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trace_enable,
    input  logic                   dct_in_valid,
    input  logic [1:0]             dct_in_code,
    output logic                   dct_in_ready,
    input  logic                   flush_req,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [CNT_W+BUF_W-1:0] frame_data,
    output logic [BUF_W-1:0]       dct_buffer,
    output logic [CNT_W-1:0]       dct_count,
    output logic [DROP_W-1:0]      dropped
);
    dct_state_e        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d, buf_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              flush_q, flush_d, te_q;
    logic              accept, full, pend, emit, load, slot_free;
    always_comb begin
        dct_in_ready = trace_enable && !(state_q == FULL_WAIT || state_q == FLUSH_WAIT);
        accept       = dct_in_valid && dct_in_ready;
        buf_nx       = accept ? {buf_q[BUF_W-3:0], dct_in_code} : buf_q;
        cnt_nx       = cnt_q + CNT_W'(accept);
        full         = cnt_nx == CNT_W'(DCT_MAX);
        // a trace_enable falling edge is just another flush source
        pend         = flush_req || (te_q && !trace_enable) || flush_q;
        emit         = full || (pend && cnt_nx != '0);
        load         = emit && slot_free;
        buf_d        = load ? '0 : buf_nx;
        cnt_d        = load ? '0 : cnt_nx;
        // a full frame already forces emission, so only partial frames keep the flush pending
        flush_d      = emit && !load && !full;
        state_d      = (load || cnt_nx == '0) ? IDLE : !emit ? COLLECT : full ? FULL_WAIT : FLUSH_WAIT;
        drop_d       = (dct_in_valid && trace_enable && !dct_in_ready && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            flush_q <= 1'b0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            flush_q <= flush_d;
            te_q    <= trace_enable;
        end
    end
    sopc_nios2_0_oci_frame_slot #(.W(CNT_W + BUF_W)) u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data ({cnt_nx, buf_nx}),
        .ready     (frame_ready),
        .valid     (frame_valid),
        .data      (frame_data),
        .slot_free (slot_free)
    );
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign dropped    = drop_q;
endmodule

// File: tb/tb_sopc_nios2_0_oci_dct_packer.sv
// tb_sopc_nios2_0_oci_dct_packer: scoreboard bench with a queue-based reference model
module tb_sopc_nios2_0_oci_dct_packer;
    import sopc_nios2_0_oci_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic        dct_in_valid = 1'b0;
    logic [1:0]  dct_in_code = 2'b00;
    logic        dct_in_ready;
    logic        flush_req = 1'b0;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [33:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  dropped;

    int errors = 0;
    int checks = 0;

    logic [33:0] exp_q[$];
    logic [1:0]  mq[$];
    bit          m_busy, m_pend, m_te_prev;
    int          m_drop;

    sopc_nios2_0_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_enable (trace_enable),
        .dct_in_valid (dct_in_valid),
        .dct_in_code  (dct_in_code),
        .dct_in_ready (dct_in_ready),
        .flush_req    (flush_req),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] pack_codes();
        logic [29:0] v = '0;
        foreach (mq[i]) v = {v[27:0], mq[i]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        chk("dct_count", 64'(dct_count), 64'(mq.size()));
        chk("dct_buffer", 64'(dct_buffer), 64'(pack_codes()));
        chk("dropped", 64'(dropped), 64'(m_drop));
        chk("frame_valid", 64'(frame_valid), 64'(m_busy));
    endtask

    // one clock: drive inputs, advance the model across the edge, check afterwards
    task automatic step(input bit v, input logic [1:0] c, input bit fl, input bit te, input bit fr);
        bit rdy, fl_ev, pend, busy_after, emit;
        rdy = te && !(mq.size() == 15 || m_pend);
        dct_in_valid = v;
        dct_in_code  = c;
        flush_req    = fl;
        trace_enable = te;
        frame_ready  = fr;
        #1;
        chk("dct_in_ready", 64'(dct_in_ready), 64'(rdy));
        fl_ev = fl || (m_te_prev && !te);
        if (v && te && !rdy && m_drop < 255) m_drop++;
        if (v && rdy) mq.push_back(c);
        pend       = fl_ev || m_pend;
        busy_after = m_busy && !fr;
        emit       = mq.size() == 15 || (pend && mq.size() > 0);
        if (emit && !busy_after) begin
            exp_q.push_back({4'(mq.size()), pack_codes()});
            mq.delete();
            m_busy = 1'b1;
            m_pend = 1'b0;
        end else begin
            m_busy = busy_after;
            m_pend = emit && mq.size() != 15;
        end
        m_te_prev = te;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        trace_enable = 1'b0;
        dct_in_valid = 1'b0;
        flush_req    = 1'b0;
        frame_ready  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_count", 64'(dct_count), 0);
        chk("rst_buffer", 64'(dct_buffer), 0);
        chk("rst_frame_valid", 64'(frame_valid), 0);
        chk("rst_frame_data", 64'(frame_data), 0);
        chk("rst_dropped", 64'(dropped), 0);
        chk("rst_ready_low", 64'(dct_in_ready), 0);
        trace_enable = 1'b1;
        #1 chk("rst_ready_high", 64'(dct_in_ready), 1);
        trace_enable = 1'b0;
        mq.delete();
        exp_q.delete();
        m_busy = 0;
        m_pend = 0;
        m_drop = 0;
        m_te_prev = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 check_state();
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (reset_n && frame_valid && frame_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected: got %0h expected no frame", frame_data);
            end else begin
                e = exp_q.pop_front();
                if (frame_data !== e) begin
                    errors++;
                    $display("FAIL frame_data: got %0h expected %0h", frame_data, e);
                end
            end
        end
    end

    initial begin
        bit te_r;
        do_reset();
        // fill with TAKEN codes, downstream always ready
        repeat (15) step(1, DCT_TAKEN, 0, 1, 1);
        chk("fill_frame", 64'(frame_data), 64'h3_FFFF_FFFF);
        step(0, DCT_NONE, 0, 1, 1);
        // partial flush of three codes
        step(1, DCT_NOT_TAKEN, 0, 1, 1);
        step(1, DCT_TAKEN, 0, 1, 1);
        step(1, DCT_NOT_TAKEN, 0, 1, 1);
        step(0, DCT_NONE, 1, 1, 1);
        chk("partial_frame", 64'(frame_data), 64'h0_C000_002E);
        step(0, DCT_NONE, 0, 1, 1);
        // flush with an empty buffer produces nothing
        step(0, DCT_NONE, 1, 1, 1);
        chk("empty_flush", 64'(frame_valid), 0);
        step(0, DCT_NONE, 0, 1, 1);
        // backpressure through two full frames
        repeat (30) step(1, 2'($urandom), 0, 1, 0);
        chk("full_wait_ready", 64'(dct_in_ready), 0);
        repeat (5) step(1, 2'($urandom), 0, 1, 0);
        chk("dropped_five", 64'(dropped), 5);
        step(0, DCT_NONE, 0, 1, 1);
        step(0, DCT_NONE, 0, 1, 1);
        // accept and flush together on the 15th code
        repeat (14) step(1, 2'($urandom), 0, 1, 1);
        step(1, 2'($urandom), 1, 1, 1);
        repeat (2) step(0, DCT_NONE, 0, 1, 1);
        // trace_enable falls at count 7
        repeat (7) step(1, 2'($urandom), 0, 1, 1);
        repeat (4) step(1, 2'($urandom), 0, 0, 1);
        chk("te_fall_dropped", 64'(dropped), 5);
        step(0, DCT_NONE, 0, 1, 1);
        // dropped counter saturation
        repeat (30) step(1, 2'($urandom), 0, 1, 0);
        repeat (260) step(1, 2'($urandom), 0, 1, 0);
        chk("dropped_sat", 64'(dropped), 8'hFF);
        repeat (2) step(0, DCT_NONE, 0, 1, 1);
        // reset at count 9 with the slot busy
        repeat (24) step(1, 2'($urandom), 0, 1, 0);
        do_reset();
        step(1, DCT_TAKEN, 0, 1, 1);
        chk("post_reset_count", 64'(dct_count), 1);
        // randomized traffic
        te_r = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) te_r = !te_r;
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 11) == 0, te_r,
                 $urandom_range(0, 9) < 7);
        end
        repeat (40) step(0, DCT_NONE, 0, 1, 1);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
